// File: rtl/msdap_p2s_pkg.sv
// ---------------------------------------------------------------------------
// msdap_p2s_pkg
//   Shared definitions for the MSDAP parallel-to-serial output stage:
//   default widths, FSM state type, per-channel shift-register operation
//   encoding and a saturating increment helper for the diagnostic counters.
// ---------------------------------------------------------------------------
package msdap_p2s_pkg;

    localparam int DATA_W_DEF = 40;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    // Operation applied to each channel's shift register on the next edge.
    typedef enum logic [1:0] {
        SH_CLEAR     = 2'd0,
        SH_SHIFT     = 2'd1,
        SH_LOAD_HOLD = 2'd2,
        SH_LOAD_DIN  = 2'd3
    } sh_op_t;

    // Saturating increment; caller passes the all-ones value of its width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/msdap_p2s_chan.sv
// ---------------------------------------------------------------------------
// msdap_p2s_chan
//   One serial output channel: a hold register that buffers one captured
//   result word and a shift register that streams it out MSB-first.
//   All sequencing decisions come from the top; this block only executes.
// Ports
//   Sclk     in   clock
//   Reset    in   synchronous active-high reset
//   sh_op    in   shift-register operation for this edge
//   hold_we  in   write din into the hold register
//   din      in   DATA_W result word from the ALU controller
//   ser_out  out  serial bit, MSB of the shift register
// ---------------------------------------------------------------------------
module msdap_p2s_chan
    import msdap_p2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Sclk,
    input  logic              Reset,
    input  sh_op_t            sh_op,
    input  logic              hold_we,
    input  logic [DATA_W-1:0] din,
    output logic              ser_out
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shreg_q;

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            hold_q  <= '0;
            shreg_q <= '0;
        end else begin
            if (hold_we)
                hold_q <= din;
            // Loading from hold and writing hold in the same edge is legal:
            // the shift register takes the old hold contents.
            case (sh_op)
                SH_CLEAR:     shreg_q <= '0;
                SH_SHIFT:     shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                SH_LOAD_HOLD: shreg_q <= hold_q;
                SH_LOAD_DIN:  shreg_q <= din;
                default:      shreg_q <= shreg_q;
            endcase
        end
    end

    assign ser_out = shreg_q[DATA_W-1];

endmodule

// File: rtl/msdap_p2s_serializer.sv
// ---------------------------------------------------------------------------
// msdap_p2s_serializer
//   Output end of the ALU controller -> serial-out path. Captures the
//   left/right results on the rising edge of P2S_status, holds them, and
//   shifts both channels out in lockstep starting at the next Frame pulse.
// Ports
//   Sclk, Reset              clock, synchronous active-high reset
//   Frame                    frame sync; start = rising edge
//   P2S_status               result-valid level; capture = rising edge
//   OutputdataL/R            DATA_W result words
//   OutputL/R                serial bits, MSB-first
//   OutReady                 high while a valid word is shifting
//   p2s_ack                  1-cycle pulse after a word is accepted
//   overrun/underrun         sticky error flags
//   ovr_cnt/und_cnt          saturating error counters (P2S_DIAG_EN only,
//                            otherwise tied to 0)
// Configuration macro: P2S_DIAG_EN
// ---------------------------------------------------------------------------
module msdap_p2s_serializer
    import msdap_p2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Sclk,
    input  logic              Reset,
    input  logic              Frame,
    input  logic              P2S_status,
    input  logic [DATA_W-1:0] OutputdataL,
    input  logic [DATA_W-1:0] OutputdataR,
    output logic              OutputL,
    output logic              OutputR,
    output logic              OutReady,
    output logic              p2s_ack,
    output logic              overrun,
    output logic              underrun,
    output logic [CNT_W-1:0]  ovr_cnt,
    output logic [CNT_W-1:0]  und_cnt
);

    localparam int NUM_LANES = 2;   // lane 0 = left, lane 1 = right
    localparam int BC_W      = $clog2(DATA_W);

    // ---------------- edge detect ----------------
    logic frame_q, stat_q;
    logic start, cap;

    assign start = Frame & ~frame_q;
    assign cap   = P2S_status & ~stat_q;

    // ---------------- FSM / sequencing ----------------
    p2s_state_t       state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             rdy_q, rdy_d;
    sh_op_t           sh_op;

    logic hold_full_q, hold_full_d;
    logic hold_we;
    logic ack_d;
    logic ovr_ev, und_ev;

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rdy_q     <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rdy_d     = rdy_q;
        sh_op     = (state_q == SHIFT) ? SH_SHIFT : SH_CLEAR;

        if (start) begin
            // Frame always wins, truncating any word still in flight.
            state_d   = SHIFT;
            bit_cnt_d = BC_W'(DATA_W - 1);
            if (hold_full_q) begin
                sh_op = SH_LOAD_HOLD;
                rdy_d = 1'b1;
            end else if (cap) begin
                // Word arrives on the frame edge itself: skip the hold stage.
                sh_op = SH_LOAD_DIN;
                rdy_d = 1'b1;
            end else begin
                sh_op = SH_CLEAR;
                rdy_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: rdy_d = 1'b0;
                SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        state_d = IDLE;
                        rdy_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- hold / handshake ----------------
    // On a frame edge the hold is emptied into the shift register, so a
    // simultaneous capture can refill it; a bypass capture never touches it.
    assign hold_we     = cap & (start ? hold_full_q : ~hold_full_q);
    assign hold_full_d = start ? (hold_full_q & cap) : (hold_full_q | cap);
    assign ack_d       = cap & (start | ~hold_full_q);
    assign ovr_ev      = cap & hold_full_q & ~start;
    assign und_ev      = start & ~hold_full_q & ~cap;

    logic ack_q, ovr_q, und_q;

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            frame_q     <= 1'b0;
            stat_q      <= 1'b0;
            hold_full_q <= 1'b0;
            ack_q       <= 1'b0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            frame_q     <= Frame;
            stat_q      <= P2S_status;
            hold_full_q <= hold_full_d;
            ack_q       <= ack_d;
            ovr_q       <= ovr_q | ovr_ev;
            und_q       <= und_q | und_ev;
        end
    end

    // ---------------- channels ----------------
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_din;
    logic [NUM_LANES-1:0]             lane_ser;

    assign lane_din[0] = OutputdataL;
    assign lane_din[1] = OutputdataR;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        msdap_p2s_chan #(.DATA_W(DATA_W)) u_chan (
            .Sclk    (Sclk),
            .Reset   (Reset),
            .sh_op   (sh_op),
            .hold_we (hold_we),
            .din     (lane_din[g]),
            .ser_out (lane_ser[g])
        );
    end

    assign OutputL  = lane_ser[0];
    assign OutputR  = lane_ser[1];
    assign OutReady = rdy_q;
    assign p2s_ack  = ack_q;
    assign overrun  = ovr_q;
    assign underrun = und_q;

    // ---------------- diagnostic counters ----------------
`ifdef P2S_DIAG_EN
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] ovr_cnt_q, und_cnt_q;

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            ovr_cnt_q <= '0;
            und_cnt_q <= '0;
        end else begin
            if (ovr_ev)
                ovr_cnt_q <= CNT_W'(sat_inc(32'(ovr_cnt_q), CNT_MAX));
            if (und_ev)
                und_cnt_q <= CNT_W'(sat_inc(32'(und_cnt_q), CNT_MAX));
        end
    end

    assign ovr_cnt = ovr_cnt_q;
    assign und_cnt = und_cnt_q;
`else
    assign ovr_cnt = '0;
    assign und_cnt = '0;
`endif

endmodule

// File: tb/tb_msdap_p2s_serializer.sv
module tb_msdap_p2s_serializer;

    localparam int DW = 40;
    localparam int CW = 8;

`ifdef P2S_DIAG_EN
    localparam int DIAG = 1;
`else
    localparam int DIAG = 0;
`endif

    logic          Sclk = 1'b0;
    logic          Reset, Frame, P2S_status;
    logic [DW-1:0] OutputdataL, OutputdataR;
    logic          OutputL, OutputR, OutReady, p2s_ack, overrun, underrun;
    logic [CW-1:0] ovr_cnt, und_cnt;

    msdap_p2s_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .Sclk        (Sclk),
        .Reset       (Reset),
        .Frame       (Frame),
        .P2S_status  (P2S_status),
        .OutputdataL (OutputdataL),
        .OutputdataR (OutputdataR),
        .OutputL     (OutputL),
        .OutputR     (OutputR),
        .OutReady    (OutReady),
        .p2s_ack     (p2s_ack),
        .overrun     (overrun),
        .underrun    (underrun),
        .ovr_cnt     (ovr_cnt),
        .und_cnt     (und_cnt)
    );

    always #5 Sclk = ~Sclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    // Called right after the load edge; checks every bit and the drop of OutReady.
    task automatic shift_rest(input logic [DW-1:0] eL, input logic [DW-1:0] eR, input string nm);
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("%s rdy b%0d", nm, i), 64'(OutReady), 64'd1);
            chk($sformatf("%s L b%0d", nm, i), 64'(OutputL), 64'(eL[DW-1-i]));
            chk($sformatf("%s R b%0d", nm, i), 64'(OutputR), 64'(eR[DW-1-i]));
            if (i < DW - 1) tick();
        end
        tick();
        chk({nm, " rdy end"}, 64'(OutReady), 64'd0);
    endtask

    typedef struct {
        logic          frame;
        logic          stat;
        logic [DW-1:0] dl;
        logic [DW-1:0] dr;
        logic          rdy;
        logic          ol;
        logic          orr;
        logic          ack;
        logic          ovr;
        logic          und;
    } vec_t;

    vec_t vt[6];

    localparam logic [DW-1:0] A  = 40'hC3_5A00_0F0F;
    localparam logic [DW-1:0] RA = 40'h12_3456_789A;
    localparam logic [DW-1:0] B  = 40'hFF_0000_0000;
    localparam logic [DW-1:0] C  = 40'hA5_F00F_3C69;
    localparam logic [DW-1:0] RC = 40'h5A_0FF0_C396;
    localparam logic [DW-1:0] D  = 40'h96_1234_ABCD;
    localparam logic [DW-1:0] RD = 40'h69_EDCB_5432;

    initial begin
        // underrun then capture A, then dropped capture B
        vt[0] = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b0, 1'b1, A,  RA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 1'b1, B,  B,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        Reset = 1'b1; Frame = 1'b0; P2S_status = 1'b0;
        OutputdataL = '0; OutputdataR = '0;
        tick(); tick();
        chk("rst OutputL",  64'(OutputL),  64'd0);
        chk("rst OutputR",  64'(OutputR),  64'd0);
        chk("rst OutReady", 64'(OutReady), 64'd0);
        chk("rst p2s_ack",  64'(p2s_ack),  64'd0);
        chk("rst overrun",  64'(overrun),  64'd0);
        chk("rst underrun", 64'(underrun), 64'd0);
        chk("rst ovr_cnt",  64'(ovr_cnt),  64'd0);
        chk("rst und_cnt",  64'(und_cnt),  64'd0);
        Reset = 1'b0;
        tick();

        // 1: capture into hold, then frame
        P2S_status = 1'b1; OutputdataL = 40'h80_0000_0001; OutputdataR = 40'h00_0000_0003;
        tick();
        chk("t1 ack", 64'(p2s_ack), 64'd1);
        chk("t1 rdy before frame", 64'(OutReady), 64'd0);
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        chk("t1 ack once", 64'(p2s_ack), 64'd0);
        shift_rest(40'h80_0000_0001, 40'h00_0000_0003, "t1");

        // 2: bypass, capture on the frame edge with hold empty
        P2S_status = 1'b0;
        tick();
        Frame = 1'b1; P2S_status = 1'b1; OutputdataL = 40'hFF_FFFF_FFFF; OutputdataR = '0;
        tick();
        Frame = 1'b0;
        chk("t2 ack", 64'(p2s_ack), 64'd1);
        chk("t2 underrun", 64'(underrun), 64'd0);
        tick();
        chk("t2 ack once", 64'(p2s_ack), 64'd0);
        chk("t2 L b1", 64'(OutputL), 64'd1);
        chk("t2 rdy b1", 64'(OutReady), 64'd1);
        for (int i = 2; i < DW; i++) tick();
        chk("t2 L lsb", 64'(OutputL), 64'd1);
        chk("t2 rdy lsb", 64'(OutReady), 64'd1);
        tick();
        chk("t2 rdy end", 64'(OutReady), 64'd0);
        chk("t2 underrun end", 64'(underrun), 64'd0);

        // 3/4: table-driven underrun + overrun
        for (int v = 0; v < 6; v++) begin
            Frame = vt[v].frame; P2S_status = vt[v].stat;
            OutputdataL = vt[v].dl; OutputdataR = vt[v].dr;
            tick();
            chk($sformatf("vec%0d rdy", v), 64'(OutReady), 64'(vt[v].rdy));
            chk($sformatf("vec%0d L", v),   64'(OutputL),  64'(vt[v].ol));
            chk($sformatf("vec%0d R", v),   64'(OutputR),  64'(vt[v].orr));
            chk($sformatf("vec%0d ack", v), 64'(p2s_ack),  64'(vt[v].ack));
            chk($sformatf("vec%0d ovr", v), 64'(overrun),  64'(vt[v].ovr));
            chk($sformatf("vec%0d und", v), 64'(underrun), 64'(vt[v].und));
        end
        chk("t34 ovr_cnt", 64'(ovr_cnt), 64'(DIAG));
        chk("t34 und_cnt", 64'(und_cnt), 64'(DIAG));
        // frame during the underrun word truncates it and shifts held A (not B)
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        shift_rest(A, RA, "t3");
        chk("t3 ovr_cnt after", 64'(ovr_cnt), 64'(DIAG));

        // 5: load D from hold while C is captured on the same edge, then
        //    a second frame mid-word switches to C without a gap
        P2S_status = 1'b1; OutputdataL = D; OutputdataR = RD;
        tick();
        P2S_status = 1'b0;
        tick();
        Frame = 1'b1; P2S_status = 1'b1; OutputdataL = C; OutputdataR = RC;
        tick();
        Frame = 1'b0;
        chk("t5 ack refill", 64'(p2s_ack), 64'd1);
        for (int i = 0; i <= 20; i++) begin
            chk($sformatf("t5 D rdy b%0d", i), 64'(OutReady), 64'd1);
            chk($sformatf("t5 D L b%0d", i), 64'(OutputL), 64'(D[DW-1-i]));
            chk($sformatf("t5 D R b%0d", i), 64'(OutputR), 64'(RD[DW-1-i]));
            if (i < 20) tick();
        end
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        chk("t5 ovr_cnt unchanged", 64'(ovr_cnt), 64'(DIAG));
        shift_rest(C, RC, "t5 C");

        // 6: reset mid-word
        P2S_status = 1'b0;
        tick();
        P2S_status = 1'b1; OutputdataL = A; OutputdataR = RA;
        tick();
        Frame = 1'b1;
        tick();
        Frame = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t6 L b%0d", i), 64'(OutputL), 64'(A[DW-1-i]));
            tick();
        end
        Reset = 1'b1;
        tick();
        chk("t6 L",        64'(OutputL),  64'd0);
        chk("t6 R",        64'(OutputR),  64'd0);
        chk("t6 rdy",      64'(OutReady), 64'd0);
        chk("t6 ack",      64'(p2s_ack),  64'd0);
        chk("t6 overrun",  64'(overrun),  64'd0);
        chk("t6 underrun", 64'(underrun), 64'd0);
        chk("t6 ovr_cnt",  64'(ovr_cnt),  64'd0);
        chk("t6 und_cnt",  64'(und_cnt),  64'd0);
        Reset = 1'b0;
        tick(); tick();
        chk("t6 idle rdy", 64'(OutReady), 64'd0);
        chk("t6 idle L",   64'(OutputL),  64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
